xnor_prbs_checker: RTL and testbench
====================================

// Module: xnor_prbs_checker
// PURPOSE
//  Receive-side PRBS checker for serial streams from our XNOR-feedback LFSR generators.
//  Self-synchronises a local LFSR to the incoming bitstream, declares lock and counts bit errors.
//  Sits at the far end of a serial link or DUT path, on the same clock as din/din_valid.
// PARAMETERS
//  WIDTH     7   LFSR length; first feedback tap is bit WIDTH-1 (x^WIDTH)
//  TAP       6   second feedback tap position (x^TAP), 1 <= TAP < WIDTH
//  LOCK_CNT  16  consecutive matching bits in SYNC required to declare lock
//  LOSS_CNT  8   consecutive mismatching bits in LOCKED that drop lock
//  CNT_W     16  err_count width
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      asynchronous, active-high reset
//  din        in   1      received serial bit
//  din_valid  in   1      din sampled only when 1
//  clear      in   1      synchronous clear of err_count (and bit_count)
//  locked     out  1      1 = checker in LOCKED state
//  err_pulse  out  1      one-cycle pulse per mismatched bit while locked
//  err_count  out  CNT_W  saturating error count
// BEHAVIOUR
//  - Reset (async, rst=1): state SEED, lfsr=0, seed/match/bad counters=0, locked=0, err_pulse=0, err_count=0.
//  - Prediction: p = ~(lfsr[WIDTH-1] ^ lfsr[TAP-1]); shift is lfsr <= {lfsr[WIDTH-2:0], bit_in}.
//  - All state advances only on clk edges with din_valid=1; din_valid=0 freezes state, err_pulse=0.
//  - SEED: bit_in=din; after WIDTH valid bits -> SYNC. If the loaded lfsr is all-ones (XNOR lockup), restart SEED instead.
//  - SYNC: bit_in=din; din==p -> match_cnt++; match_cnt reaches LOCK_CNT -> LOCKED.
//    din!=p -> SEED, match_cnt=0, seed counter=0. No errors counted in SEED/SYNC.
//  - LOCKED: bit_in=p (free-running, errors do not propagate into lfsr).
//    din!=p -> err_pulse=1 next cycle, err_count++ (saturates at 2^CNT_W-1), bad_run++.
//    din==p -> bad_run=0. bad_run reaches LOSS_CNT -> SEED, locked=0; err_count retained.
//  - Latency: locked and err_pulse are registered; they change in the cycle after the deciding valid bit is sampled.
//    Clean stream: locked=1 after WIDTH+LOCK_CNT valid bits (23 with defaults).
//  - clear: err_count=0 next cycle, lock state untouched; clear coincident with an error -> clear wins (count 0), err_pulse still 1.
//  - rst mid-stream: immediate return to reset values; relock needs full SEED+SYNC again.
// CONFIGURATION
//  PRBS_CHK_BITCNT_EN defined: extra port bit_count out 32, counts valid bits sampled in LOCKED
//    (including errored ones), wraps at 2^32, reset 0, zeroed by clear; leaving LOCKED holds its value.
//  Undefined: bit_count port and counter absent; all other behaviour identical.
// TESTING
//  1. Clean PRBS7 from XNOR generator (seed 7'h00), continuous valid -> locked=1 cycle after 23rd bit; 254 more bits -> err_count=0.
//  2. After lock, invert 3 isolated bits -> exactly 3 err_pulse cycles, err_count=3, locked stays 1.
//  3. After lock, invert 8 consecutive bits -> locked=0 after 8th, err_count=8; 23 further clean bits -> locked=1.
//  4. Constant all-ones stream for 100 bits -> locked never asserts, err_count=0.
//  5. Locked stream with din_valid toggling 1/0 each cycle -> no false errors, lock held; clear on an error cycle -> err_count=0, err_pulse=1.
//  6. Assert rst for 1 cycle mid-lock -> locked=0, err_count=0 asynchronously; relock after 23 valid bits.

Source files
------------

// File: rtl/xnor_prbs_checker.sv
// xnor_prbs_checker
// Receive-side checker for streams from XNOR-feedback LFSR generators.
// The checker seeds a local LFSR from the incoming bits, confirms that seed
// with a run of correct predictions, then free-runs and counts mismatches as
// bit errors. A sustained run of mismatches drops lock and starts over.
// Optional feature: define PRBS_CHK_BITCNT_EN to add the 32-bit bit_count
// output, which counts valid bits sampled while locked.

module xnor_prbs_checker #(
  parameter int WIDTH    = 7,
  parameter int TAP      = 6,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int SEED_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(LOSS_CNT + 1);

  // Terminal values: the count reaches its limit on the bit that hits these.
  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(LOSS_CNT - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   lfsr;
  logic [SEED_W-1:0]  seed_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [BAD_W-1:0]   bad_run;

  logic             predict;
  logic             mismatch;
  logic             bit_in;
  logic [WIDTH-1:0] seeded;
  logic             lockup;
  logic             err_hit;

  // Next expected bit from the local LFSR, and what gets shifted in: the
  // received bit while acquiring, the prediction once locked so that line
  // errors never corrupt the local sequence.
  assign predict  = ~(lfsr[WIDTH-1] ^ lfsr[TAP-1]);
  assign mismatch = din ^ predict;
  assign bit_in   = (state == ST_LOCKED) ? predict : din;
  assign seeded   = {lfsr[WIDTH-2:0], din};
  assign lockup   = &seeded;   // all-ones is the XNOR LFSR's dead state
  assign err_hit  = din_valid & (state == ST_LOCKED) & mismatch;
  assign locked   = (state == ST_LOCKED);

  // Acquisition / lock state machine and local LFSR, advanced per valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments on every register so all flops update
      // together from pre-edge values, independent of statement order.
      state     <= ST_SEED;
      lfsr      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      bad_run   <= '0;
    end else if (din_valid) begin
      lfsr <= {lfsr[WIDTH-2:0], bit_in};
      case (state)
        ST_SEED: begin
          if (seed_cnt == SEED_LAST) begin
            seed_cnt  <= '0;
            match_cnt <= '0;
            if (!lockup) state <= ST_SYNC;
          end else begin
            seed_cnt <= seed_cnt + 1'b1;
          end
        end
        ST_SYNC: begin
          if (!mismatch) begin
            if (match_cnt == MATCH_LAST) begin
              state     <= ST_LOCKED;
              match_cnt <= '0;
              bad_run   <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            state     <= ST_SEED;
            match_cnt <= '0;
            seed_cnt  <= '0;
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            if (bad_run == BAD_LAST) begin
              state    <= ST_SEED;
              bad_run  <= '0;
              seed_cnt <= '0;
            end else begin
              bad_run <= bad_run + 1'b1;
            end
          end else begin
            bad_run <= '0;
          end
        end
        default: begin
          state     <= ST_SEED;
          seed_cnt  <= '0;
          match_cnt <= '0;
          bad_run   <= '0;
        end
      endcase
    end
  end

  // Error pulse and saturating error counter; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_hit;
      if (clear) begin
        err_count <= '0;
      end else if (err_hit && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  // Wrapping count of valid bits checked while locked; holds when lock drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count <= '0;
    end else if (clear) begin
      bit_count <= '0;
    end else if (din_valid && (state == ST_LOCKED)) begin
      bit_count <= bit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Testbench for xnor_prbs_checker: a stimulus process drives a PRBS7 stream
// (with injected errors, gaps and clears) and pushes the expected outputs of
// a history-based reference model into a queue; a monitor process pops and
// compares after every clock edge. Directed checks pin the key numbers.

module tb_xnor_prbs_checker;

  localparam int WIDTH    = 7;
  localparam int TAP      = 6;
  localparam int LOCK_CNT = 16;
  localparam int LOSS_CNT = 8;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0]      bit_count;
`endif

  always #5 clk = ~clk;

  xnor_prbs_checker #(
    .WIDTH(WIDTH), .TAP(TAP), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  typedef struct {
    logic             locked;
    logic             pulse;
    logic [CNT_W-1:0] err;
    logic [31:0]      bits;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   pulse_seen = 0;
  bit   lock_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The checker's view of the stream is a history of "effective" bits: the
  // received bit while acquiring, the predicted bit once locked. The next
  // expected bit is the XNOR of the bits WIDTH and TAP positions back.
  typedef enum int {M_SEED, M_SYNC, M_LOCKED} mphase_t;
  mphase_t     m_phase;
  bit          m_hist[$];
  int          m_nseed, m_nmatch, m_nbad;
  longint      m_err;
  bit [31:0]   m_bits;

  function automatic void model_reset();
    m_phase = M_SEED;
    m_hist  = {};
    for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
    m_nseed  = 0;
    m_nmatch = 0;
    m_nbad   = 0;
    m_err    = 0;
  endfunction

  function automatic exp_t model_step(input bit d, input bit v, input bit clr);
    exp_t e;
    bit   p;
    bit   all1;
    e.pulse = 1'b0;
    if (v) begin
      p = ~(m_hist[m_hist.size()-WIDTH] ^ m_hist[m_hist.size()-TAP]);
      case (m_phase)
        M_SEED: begin
          m_hist.push_back(d);
          m_nseed++;
          if (m_nseed == WIDTH) begin
            m_nseed = 0;
            all1 = 1'b1;
            for (int i = 1; i <= WIDTH; i++) all1 &= m_hist[m_hist.size()-i];
            if (!all1) begin
              m_phase  = M_SYNC;
              m_nmatch = 0;
            end
          end
        end
        M_SYNC: begin
          m_hist.push_back(d);
          if (d == p) begin
            m_nmatch++;
            if (m_nmatch == LOCK_CNT) begin
              m_phase = M_LOCKED;
              m_nbad  = 0;
            end
          end else begin
            m_phase  = M_SEED;
            m_nseed  = 0;
            m_nmatch = 0;
          end
        end
        default: begin
          m_hist.push_back(p);
          m_bits++;
          if (d != p) begin
            e.pulse = 1'b1;
            if (m_err < (longint'(1) << CNT_W) - 1) m_err++;
            m_nbad++;
            if (m_nbad == LOSS_CNT) begin
              m_phase = M_SEED;
              m_nseed = 0;
              m_nbad  = 0;
            end
          end else begin
            m_nbad = 0;
          end
        end
      endcase
      if (m_hist.size() > 4 * WIDTH) void'(m_hist.pop_front());
    end
    if (clr) begin
      m_err  = 0;
      m_bits = '0;
    end
    e.locked = (m_phase == M_LOCKED);
    e.err    = m_err[CNT_W-1:0];
    e.bits   = m_bits;
    return e;
  endfunction

  // ---------------- PRBS source: b[n] = ~(b[n-WIDTH] ^ b[n-TAP]), seed 0 ----
  bit g_hist[$];

  function automatic bit gen_next();
    bit b;
    b = ~(g_hist[g_hist.size()-WIDTH] ^ g_hist[g_hist.size()-TAP]);
    g_hist.push_back(b);
    if (g_hist.size() > 4 * WIDTH) void'(g_hist.pop_front());
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  // NOTE: stimulus is driven with blocking assignments on the falling edge so
  // the DUT samples settled inputs at the next rising edge.
  task automatic drive(input bit d, input bit v, input bit clr);
    @(negedge clk);
    din       = d;
    din_valid = v;
    clear     = clr;
    exp_q.push_back(model_step(d, v, clr));
  endtask

  task automatic send_good(input int n);
    repeat (n) drive(gen_next(), 1'b1, 1'b0);
  endtask

  task automatic send_err(input int n);
    repeat (n) drive(~gen_next(), 1'b1, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    din_valid = 1'b0;
    clear     = 1'b0;
    rst       = 1'b1;
    model_reset();
    #1;
    check($sformatf("%s_rst_locked", tag), locked, 1'b0);
    check($sformatf("%s_rst_err_count", tag), err_count, '0);
    check($sformatf("%s_rst_err_pulse", tag), err_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_locked", locked, e.locked);
        check("sb_err_pulse", err_pulse, e.pulse);
        check("sb_err_count", err_count, e.err);
`ifdef PRBS_CHK_BITCNT_EN
        check("sb_bit_count", bit_count, e.bits);
`endif
        if (err_pulse) pulse_seen++;
        if (locked) lock_seen = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int p0;
    bit v, e, c;

    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    clear     = 1'b0;
    m_bits    = '0;
    model_reset();
    for (int i = 0; i < WIDTH; i++) g_hist.push_back(1'b0);
    #12;
    check("reset_locked", locked, 1'b0);
    check("reset_err_pulse", err_pulse, 1'b0);
    check("reset_err_count", err_count, '0);
`ifdef PRBS_CHK_BITCNT_EN
    check("reset_bit_count", bit_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 1: clean PRBS7, lock exactly after bit 23, then 254 error-free bits.
    send_good(22);
    settle();
    check("t1_not_locked_at_22", locked, 1'b0);
    send_good(1);
    settle();
    check("t1_locked_at_23", locked, 1'b1);
    send_good(254);
    settle();
    check("t1_err_count", err_count, '0);
    check("t1_still_locked", locked, 1'b1);

    // 2: three isolated inverted bits.
    p0 = pulse_seen;
    for (int k = 0; k < 3; k++) begin
      send_good(10);
      send_err(1);
    end
    send_good(10);
    settle();
    check("t2_err_count", err_count, 16'd3);
    check("t2_pulse_cycles", pulse_seen - p0, 3);
    check("t2_locked", locked, 1'b1);

    // 3: eight consecutive inverted bits drop lock; 23 clean bits relock.
    drive(gen_next(), 1'b1, 1'b1);
    send_err(7);
    settle();
    check("t3_locked_after_7", locked, 1'b1);
    check("t3_err_after_7", err_count, 16'd7);
    send_err(1);
    settle();
    check("t3_unlocked_after_8", locked, 1'b0);
    check("t3_err_after_8", err_count, 16'd8);
    send_good(22);
    settle();
    check("t3_not_relocked_22", locked, 1'b0);
    send_good(1);
    settle();
    check("t3_relocked_23", locked, 1'b1);
    check("t3_err_retained", err_count, 16'd8);

    // 4: all-ones stream never locks (XNOR lockup state).
    async_reset("t4");
    lock_seen = 1'b0;
    repeat (100) drive(1'b1, 1'b1, 1'b0);
    settle();
    check("t4_lock_never_seen", lock_seen, 1'b0);
    check("t4_err_count", err_count, '0);

    // 5: gapped valid after lock, then clear colliding with an error.
    async_reset("t5");
    send_good(23);
    settle();
    check("t5_locked", locked, 1'b1);
    for (int k = 0; k < 40; k++) begin
      drive(gen_next(), 1'b1, 1'b0);
      drive(1'($urandom_range(1)), 1'b0, 1'b0);
    end
    settle();
    check("t5_gap_err_count", err_count, '0);
    check("t5_gap_locked", locked, 1'b1);
    send_err(1);
    send_good(5);
    send_err(1);
    send_good(5);
    settle();
    check("t5_err_before_clear", err_count, 16'd2);
    drive(~gen_next(), 1'b1, 1'b1);
    settle();
    check("t5_clear_wins", err_count, '0);
    check("t5_pulse_on_clear", err_pulse, 1'b1);
    check("t5_locked_after_clear", locked, 1'b1);

    // 6: reset mid-lock, then full reacquisition.
    send_good(5);
    send_err(1);
    send_good(3);
    settle();
    check("t6_err_before_rst", err_count, 16'd1);
    async_reset("t6");
    send_good(22);
    settle();
    check("t6_not_locked_22", locked, 1'b0);
    send_good(1);
    settle();
    check("t6_locked_23", locked, 1'b1);

    // Random traffic: gaps, sparse errors, occasional bursts and clears.
    repeat (3000) begin
      if ($urandom_range(499) == 0) begin
        send_err(10);
      end else begin
        v = ($urandom_range(3) != 0);
        e = ($urandom_range(31) == 0);
        c = ($urandom_range(127) == 0);
        if (v) drive(gen_next() ^ e, 1'b1, c);
        else   drive(1'($urandom_range(1)), 1'b0, c);
      end
    end
    settle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
